// File: rtl/stack_mem_if.sv
// Bundle between the memory-stage controller, the pipeline and the 2K x 16 data memory.
// slave is the controller's view; master is the pipeline/memory side.
interface stack_mem_if;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        fault;
   logic [15:0] sp_out;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, fault, sp_out,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, fault, sp_out,
             mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Memory-stage initiator: turns load/store/stack requests into one or two
// range-checked word accesses and owns the downward-growing stack pointer.
module stack_mem_ctrl #(
   parameter logic [15:0] MEM_TOP  = 16'h07FF,
   parameter logic [15:0] SP_RESET = 16'h07FF
) (
   input  logic      clk,
   input  logic      rst,
   stack_mem_if.slave bus
);
   // state | meaning
   // IDLE  | ready for a request
   // ACC1  | first word access on the memory bus
   // ACC2  | second word access (CALL/RET only)
   // RESP  | rsp_valid pulse, fault set if the request was rejected
   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_STORE = 3'd1;
   localparam logic [2:0] OP_PUSH  = 3'd2;
   localparam logic [2:0] OP_POP   = 3'd3;
   localparam logic [2:0] OP_CALL  = 3'd4;
   localparam logic [2:0] OP_RET   = 3'd5;

   state_t      state_q, state_d;
   logic [15:0] sp_q, sp_d, sp_new_q, sp_new_d;
   logic        two_q, two_d;
   logic [15:0] addr2_q, addr2_d, wdata2_q, wdata2_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic        rd_q, rd_d, wr_q, wr_d;
   logic [15:0] addr_q, addr_d, wdata_q, wdata_d;

   // 17-bit arithmetic so a 16-bit wrap shows up in bit 16
   logic [16:0] s_p1, s_p2, s_m1, s_m2, a1, a2, sp_nx;
   logic [15:0] w1, w2;
   logic        is_rd, is_two, op_ok, addr_ok;

   function automatic logic in_range(input logic [16:0] a);
      return !a[16] && (a[15:0] <= MEM_TOP);
   endfunction

   always_comb begin
      s_p1   = {1'b0, sp_q} + 17'd1;
      s_p2   = {1'b0, sp_q} + 17'd2;
      s_m1   = {1'b0, sp_q} - 17'd1;
      s_m2   = {1'b0, sp_q} - 17'd2;
      a1     = {1'b0, bus.req_addr};
      a2     = '0;
      sp_nx  = {1'b0, sp_q};
      w1     = bus.req_wdata[15:0];
      w2     = '0;
      is_rd  = 1'b0;
      is_two = 1'b0;
      op_ok  = 1'b1;
      case (bus.req_op)
         OP_LOAD:  is_rd = 1'b1;
         OP_STORE: ;
         OP_PUSH:  begin a1 = {1'b0, sp_q}; sp_nx = s_m1; end
         OP_POP:   begin a1 = s_p1; sp_nx = s_p1; is_rd = 1'b1; end
         OP_CALL:  begin
            a1 = {1'b0, sp_q}; a2 = s_m1; sp_nx = s_m2; is_two = 1'b1;
            w1 = bus.req_wdata[31:16]; w2 = bus.req_wdata[15:0];
         end
         OP_RET:   begin a1 = s_p1; a2 = s_p2; sp_nx = s_p2; is_two = 1'b1; is_rd = 1'b1; end
         default:  op_ok = 1'b0;
      endcase
      addr_ok = op_ok && in_range(a1) && (!is_two || in_range(a2)) && !sp_nx[16];
   end

   always_comb begin
      state_d  = state_q;
      sp_d     = sp_q;
      sp_new_d = sp_new_q;
      two_d    = two_q;
      addr2_d  = addr2_q;
      wdata2_d = wdata2_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            rdata_d = '0;
            fault_d = !addr_ok;
            if (addr_ok) begin
               state_d  = ACC1;
               rd_d     = is_rd;
               wr_d     = !is_rd;
               addr_d   = a1[15:0];
               wdata_d  = is_rd ? 16'h0 : w1;
               two_d    = is_two;
               addr2_d  = a2[15:0];
               wdata2_d = is_rd ? 16'h0 : w2;
               sp_new_d = sp_nx[15:0];
            end else begin
               state_d = RESP;
            end
         end
         ACC1: begin
            if (rd_q) rdata_d[15:0] = bus.mem_rdata;
            if (two_q) begin
               state_d = ACC2;
               addr_d  = addr2_q;
               wdata_d = wdata2_q;
            end else begin
               state_d = RESP;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               addr_d  = '0;
               wdata_d = '0;
               sp_d    = sp_new_q;
            end
         end
         ACC2: begin
            if (rd_q) rdata_d[31:16] = bus.mem_rdata;
            state_d = RESP;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            sp_d    = sp_new_q;
         end
         RESP: begin
            state_d = IDLE;
            fault_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sp_q     <= SP_RESET;
         sp_new_q <= SP_RESET;
         two_q    <= 1'b0;
         addr2_q  <= '0;
         wdata2_q <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         sp_q     <= sp_d;
         sp_new_q <= sp_new_d;
         two_q    <= two_d;
         addr2_q  <= addr2_d;
         wdata2_q <= wdata2_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // rdata_q holds partial words during ACCn, so only expose it in RESP
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
   assign bus.fault     = (state_q == RESP) && fault_q;
   assign bus.sp_out    = sp_q;
   assign bus.mem_read  = rd_q;
   assign bus.mem_write = wr_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl: a negedge-sampled data memory, a request-level
// model checked every cycle, and directed sequences with literal expectations.
module tb_stack_mem_ctrl;
   localparam logic [15:0] MEM_TOP  = 16'h07FF;
   localparam logic [15:0] SP_RESET = 16'h07FF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   stack_mem_if bus();

   stack_mem_ctrl #(.MEM_TOP(MEM_TOP), .SP_RESET(SP_RESET)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            fault;
      logic [1:0]      n;
      logic [1:0]      rd;
      logic [1:0]      wr;
      logic [1:0][15:0] addr;
      logic [1:0][15:0] wd;
      logic [31:0]     rdata;
      logic [15:0]     sp_after;
   } exp_t;

   logic [15:0] ram  [0:2047] = '{default: 16'h0};
   logic [15:0] mmem [0:2047] = '{default: 16'h0};

   int   cyc = 0, tests = 0, fails = 0;
   exp_t m_e = '0;
   logic m_active = 1'b0;
   int   m_acc_cyc = 0, m_resp_cyc = 0;
   logic [15:0] m_sp = SP_RESET;
   logic m_idle;
   assign m_idle = !m_active || (cyc > m_resp_cyc);

   int   strobe_cnt = 0, rsp_cnt = 0, last_rsp_cyc = 0;
   logic [31:0] last_rdata = '0;
   logic last_fault = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // What a request must do, from the op table alone
   function automatic exp_t predict(input logic [2:0] op, input logic [15:0] a,
                                    input logic [31:0] wd, input logic [15:0] sp);
      exp_t e;
      int s, ns, ad[2];
      bit bad;
      e = '0; s = int'(sp); ns = s; bad = 1'b0; ad[0] = 0; ad[1] = 0;
      case (op)
         3'd0: begin e.n = 1; e.rd = 2'b01; ad[0] = int'(a); end
         3'd1: begin e.n = 1; e.wr = 2'b01; ad[0] = int'(a); e.wd[0] = wd[15:0]; end
         3'd2: begin e.n = 1; e.wr = 2'b01; ad[0] = s; e.wd[0] = wd[15:0]; ns = s - 1; end
         3'd3: begin e.n = 1; e.rd = 2'b01; ad[0] = s + 1; ns = s + 1; end
         3'd4: begin
            e.n = 2; e.wr = 2'b11; ad[0] = s; ad[1] = s - 1;
            e.wd[0] = wd[31:16]; e.wd[1] = wd[15:0]; ns = s - 2;
         end
         3'd5: begin e.n = 2; e.rd = 2'b11; ad[0] = s + 1; ad[1] = s + 2; ns = s + 2; end
         default: bad = 1'b1;
      endcase
      for (int k = 0; k < int'(e.n); k++)
         if (ad[k] < 0 || ad[k] > int'(MEM_TOP)) bad = 1'b1;
      if (ns < 0 || ns > 65535) bad = 1'b1;
      if (bad) begin
         e = '0;
         e.fault = 1'b1;
         e.sp_after = sp;
         return e;
      end
      for (int k = 0; k < int'(e.n); k++) e.addr[k] = 16'(ad[k]);
      e.sp_after = 16'(ns);
      if (op == 3'd0 || op == 3'd3) e.rdata = {16'h0, mmem[ad[0]]};
      if (op == 3'd5)               e.rdata = {mmem[ad[1]], mmem[ad[0]]};
      return e;
   endfunction

   always @(posedge clk) begin : model
      exp_t e;
      cyc <= cyc + 1;
      if (rst) begin
         m_active <= 1'b0;
         m_sp     <= SP_RESET;
      end else begin
         if (m_active && (cyc + 1 == m_resp_cyc)) m_sp <= m_e.sp_after;
         if (bus.req_valid && m_idle) begin
            e = predict(bus.req_op, bus.req_addr, bus.req_wdata, m_sp);
            m_e        <= e;
            m_active   <= 1'b1;
            m_acc_cyc  <= cyc + 1;
            m_resp_cyc <= cyc + 1 + int'(e.n);
         end
      end
   end

   always @(negedge clk) begin : compare
      int k;
      logic in_acc, e_rd, e_wr, is_resp;
      logic [15:0] e_addr, e_wd;
      if (cyc >= 1) begin
         k       = cyc - m_acc_cyc;
         in_acc  = m_active && (k >= 0) && (k < int'(m_e.n));
         e_rd    = in_acc && m_e.rd[k[0]];
         e_wr    = in_acc && m_e.wr[k[0]];
         e_addr  = in_acc ? m_e.addr[k[0]] : 16'h0;
         e_wd    = e_wr ? m_e.wd[k[0]] : 16'h0;
         is_resp = m_active && (cyc == m_resp_cyc);
         chk("req_ready", 32'(bus.req_ready), 32'(!(m_active && cyc <= m_resp_cyc)));
         chk("mem_read",  32'(bus.mem_read),  32'(e_rd));
         chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
         chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
         chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(is_resp));
         chk("fault",     32'(bus.fault),     32'(is_resp && m_e.fault));
         chk("rsp_rdata", bus.rsp_rdata,      is_resp ? m_e.rdata : 32'h0);
         chk("sp_out",    32'(bus.sp_out),    32'(m_sp));
         if (e_wr) mmem[e_addr[10:0]] <= e_wd;
      end
   end

   always @(negedge clk) begin : data_memory
      if (bus.mem_write) ram[bus.mem_addr[10:0]] <= bus.mem_wdata;
      if (bus.mem_read)  bus.mem_rdata <= ram[bus.mem_addr[10:0]];
   end

   always @(negedge clk) begin : monitor
      if (bus.mem_read || bus.mem_write) strobe_cnt <= strobe_cnt + 1;
      if (bus.rsp_valid) begin
         rsp_cnt      <= rsp_cnt + 1;
         last_rdata   <= bus.rsp_rdata;
         last_fault   <= bus.fault;
         last_rsp_cyc <= cyc;
      end
   end

   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [31:0] wd);
      int t;
      t = 0;
      while (!m_idle && t < 40) begin @(negedge clk); t++; end
      if (t >= 40) begin
         tests++; fails++;
         $display("FAIL send_timeout: controller not idle after %0d cycles", t);
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      // scramble request fields; only the accept-edge values may matter
      bus.req_valid = 1'b0;
      bus.req_op    = 3'b111;
      bus.req_addr  = 16'hFFFF;
      bus.req_wdata = 32'hDEADBEEF;
   endtask

   task automatic run(input logic [2:0] op, input logic [15:0] a, input logic [31:0] wd);
      int t;
      send(op, a, wd);
      t = 0;
      while (!m_idle && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) begin
         tests++; fails++;
         $display("FAIL rsp_timeout: no completion within %0d cycles", t);
      end
      @(negedge clk);
   endtask

   function automatic int lat();
      return last_rsp_cyc - m_acc_cyc + 1;
   endfunction

   initial begin : stim
      int b, rb;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_addr  = 16'h0;
      bus.req_wdata = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_sp",    32'(bus.sp_out),    32'h07FF);
      chk("rst_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_rd",    32'(bus.mem_read),  32'h0);
      chk("rst_wr",    32'(bus.mem_write), 32'h0);
      chk("rst_rsp",   32'(bus.rsp_valid), 32'h0);

      b = strobe_cnt;
      run(3'd1, 16'h0010, 32'h0000ABCD);
      chk("store_strobes", 32'(strobe_cnt - b), 32'd1);
      chk("store_ram",     32'(ram[16]),        32'h0000ABCD);
      run(3'd0, 16'h0010, 32'h0);
      chk("load_data", last_rdata,  32'h0000ABCD);
      chk("load_lat",  32'(lat()),  32'd2);

      run(3'd4, 16'h0, 32'h12345678);
      chk("call_hi", 32'(ram[11'h7FF]), 32'h1234);
      chk("call_lo", 32'(ram[11'h7FE]), 32'h5678);
      chk("call_sp", 32'(bus.sp_out),   32'h07FD);
      run(3'd5, 16'h0, 32'h0);
      chk("ret_data", last_rdata,       32'h12345678);
      chk("ret_sp",   32'(bus.sp_out),  32'h07FF);
      chk("ret_lat",  32'(lat()),       32'd3);

      b = strobe_cnt;
      run(3'd0, 16'h0800, 32'h0);
      chk("badaddr_fault", 32'(last_fault),     32'h1);
      chk("badaddr_lat",   32'(lat()),          32'd1);
      chk("badaddr_sp",    32'(bus.sp_out),     32'h07FF);
      run(3'b111, 16'h0000, 32'h0);
      chk("badop_fault",   32'(last_fault),     32'h1);
      chk("badop_data",    last_rdata,          32'h0);
      chk("fault_strobes", 32'(strobe_cnt - b), 32'd0);

      run(3'd3, 16'h0, 32'h0);
      chk("underflow_fault", 32'(last_fault),   32'h1);
      chk("underflow_sp",    32'(bus.sp_out),   32'h07FF);
      run(3'd2, 16'h0, 32'h000000AA);
      chk("push_sp",  32'(bus.sp_out),  32'h07FE);
      chk("push_ram", 32'(ram[11'h7FF]), 32'h00AA);
      run(3'd3, 16'h0, 32'h0);
      chk("pop_data",  last_rdata,      32'h000000AA);
      chk("pop_fault", 32'(last_fault), 32'h0);
      chk("pop_sp",    32'(bus.sp_out), 32'h07FF);

      run(3'd0, 16'h07FF, 32'h0);
      chk("top_load_data", last_rdata,      32'h000000AA);
      chk("top_load_flt",  32'(last_fault), 32'h0);
      run(3'd5, 16'h0, 32'h0);
      chk("ret_underflow", 32'(last_fault), 32'h1);
      run(3'd1, 16'h07FF, 32'hFFFF5A5A);
      chk("top_store_ram", 32'(ram[11'h7FF]), 32'h5A5A);

      run(3'd2, 16'h0, 32'h00001111);
      rb = rsp_cnt;
      send(3'd4, 16'h0, 32'hCAFEBABE);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_sp",    32'(bus.sp_out),    32'h07FF);
      chk("abort_rd",    32'(bus.mem_read),  32'h0);
      chk("abort_wr",    32'(bus.mem_write), 32'h0);
      chk("abort_ready", 32'(bus.req_ready), 32'h1);
      repeat (3) @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_cnt - rb),  32'd0);
      chk("abort_hi",     32'(ram[11'h7FE]),  32'hCAFE);
      chk("abort_lo",     32'(ram[11'h7FD]),  32'hBABE);

      run(3'd2, 16'h0, 32'h00000005);
      run(3'd3, 16'h0, 32'h0);
      chk("post_rst_pop", last_rdata, 32'h00000005);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
